// File: rtl/data_mem_sys_param.sv
// data_mem_sys_param: direct-mapped write-through, no-write-allocate cache over a fixed-latency word memory
module data_mem_sys_param #(
  parameter int ADDR_W = 10,
  parameter int INDEX_W = 5,
  parameter int OFFSET_W = 2,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int OW = OFFSET_W > 0 ? OFFSET_W : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_store [LINES];
  logic [DATA_W-1:0] data_store [LINES][WORDS];
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0] tg;
  logic [OW-1:0] off;
  logic [ADDR_W-1:0] blk;
  logic rd, wr, hit, commit;
  assign idx = INDEX_W'(addr >> OFFSET_W);
  assign tg = TAG_W'(addr >> (OFFSET_W + INDEX_W));
  assign off = OFFSET_W == 0 ? '0 : OW'(addr);
  assign blk = addr & ~ADDR_W'(WORDS - 1);
  // a simultaneous read and write is treated purely as a write
  assign wr = MemWrite;
  assign rd = MemRead && !MemWrite;
  assign hit = valid[idx] && tag_store[idx] == tg;
  assign commit = !reset && state == WAIT && cnt == '0;
  always_comb begin
    stall = !reset && (state == WAIT || (state == IDLE && (wr || (rd && !hit))));
    data_out = !reset && rd && ((state == IDLE && hit) || state == DONE) ? data_store[idx][off] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      valid <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd && hit) hit_count <= hit_count + 32'(hit_count != '1);
          if (rd && !hit) miss_count <= miss_count + 32'(miss_count != '1);
          if (wr || (rd && !hit)) begin
            state <= WAIT;
            cnt <= CNT_W'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= DONE;
          if (cnt == '0 && rd) valid[idx] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // storage arrays carry no reset; a reset in flight simply suppresses the commit
  always_ff @(posedge clk) begin
    if (commit && wr) begin
      mem[addr] <= data_in;
      if (hit) data_store[idx][off] <= data_in;
    end
    if (commit && rd) begin
      tag_store[idx] <= tg;
      for (int w = 0; w < WORDS; w++) data_store[idx][OW'(w)] <= mem[blk | ADDR_W'(w)];
    end
  end
endmodule

// File: tb/tb_data_mem_sys_param.sv
// tb_data_mem_sys_param: directed scoreboard bench for the default build and a small low-latency build
module tb_data_mem_sys_param;
  logic clk = 0, reset = 1, MemRead = 0, MemWrite = 0;
  logic [9:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] dout_a, dout_b, hit_a, hit_b, miss_a, miss_b;
  logic stall_a, stall_b;
  logic sel = 0;
  logic s_stall;
  logic [31:0] s_dout, s_hit, s_miss;
  int checks = 0, failures = 0;
  typedef struct { logic [31:0] data; int lat; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  data_mem_sys_param dut_a (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
    .data_in(data_in), .data_out(dout_a), .stall(stall_a), .hit_count(hit_a), .miss_count(miss_a)
  );

  data_mem_sys_param #(.MEM_LAT(1), .INDEX_W(3), .OFFSET_W(0)) dut_b (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
    .data_in(data_in), .data_out(dout_b), .stall(stall_b), .hit_count(hit_b), .miss_count(miss_b)
  );

  assign s_stall = sel ? stall_b : stall_a;
  assign s_dout = sel ? dout_b : dout_a;
  assign s_hit = sel ? hit_b : hit_a;
  assign s_miss = sel ? miss_b : miss_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one request, count stall cycles, then compare against the scoreboard entry
  task automatic op(input string tag, input logic wr, input logic rd, input logic [9:0] a,
                    input logic [31:0] d, input int lat, input logic [31:0] exp_d);
    int n;
    exp_t e;
    sb.push_back('{exp_d, lat});
    MemWrite = wr; MemRead = rd; addr = a; data_in = d;
    n = 0;
    #1;
    while (s_stall && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(n), 32'(e.lat));
    check({tag, "_data"}, s_dout, e.data);
    @(negedge clk);
    MemWrite = 0; MemRead = 0;
  endtask

  task automatic do_reset();
    reset = 1; MemRead = 0; MemWrite = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_stall", 32'(s_stall), 32'd0);
    check("rst_dout", s_dout, 32'd0);
    check("rst_hit", s_hit, 32'd0);
    check("rst_miss", s_miss, 32'd0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    do_reset();
    op("pre4", 1, 0, 10'h004, 32'h11110004, 5, 32'h0);
    op("pre5", 1, 0, 10'h005, 32'hDEADBEEF, 5, 32'h0);
    op("pre6", 1, 0, 10'h006, 32'h11110006, 5, 32'h0);
    op("pre7", 1, 0, 10'h007, 32'h11110007, 5, 32'h0);
    op("pre85", 1, 0, 10'h085, 32'hCAFE0085, 5, 32'h0);
    op("pre10", 1, 0, 10'h010, 32'h00000000, 5, 32'h0);
    check("pre_miss", s_miss, 32'd0);
    op("cold5", 0, 1, 10'h005, 32'h0, 5, 32'hDEADBEEF);
    check("cold_miss", s_miss, 32'd1);
    op("hit4", 0, 1, 10'h004, 32'h0, 0, 32'h11110004);
    op("hit6", 0, 1, 10'h006, 32'h0, 0, 32'h11110006);
    op("hit7", 0, 1, 10'h007, 32'h0, 0, 32'h11110007);
    check("hits3", s_hit, 32'd3);
    op("conf85", 0, 1, 10'h085, 32'h0, 5, 32'hCAFE0085);
    op("conf5", 0, 1, 10'h005, 32'h0, 5, 32'hDEADBEEF);
    check("conf_miss", s_miss, 32'd3);
    op("wrhit6", 1, 0, 10'h006, 32'h12345678, 5, 32'h0);
    op("rdhit6", 0, 1, 10'h006, 32'h0, 0, 32'h12345678);
    check("wrhit_hits", s_hit, 32'd4);
    op("evict85", 0, 1, 10'h085, 32'h0, 5, 32'hCAFE0085);
    op("mem6", 0, 1, 10'h006, 32'h0, 5, 32'h12345678);
    check("mem6_miss", s_miss, 32'd5);
    op("wrmiss3f0", 1, 0, 10'h3F0, 32'hA5A5A5A5, 5, 32'h0);
    op("rd3f0", 0, 1, 10'h3F0, 32'h0, 5, 32'hA5A5A5A5);
    check("wrmiss_miss", s_miss, 32'd6);
    op("both3f0", 1, 1, 10'h3F0, 32'h00005A5A, 5, 32'h0);
    check("both_hit", s_hit, 32'd4);
    check("both_miss", s_miss, 32'd6);
    op("rdboth", 0, 1, 10'h3F0, 32'h0, 0, 32'h00005A5A);
    check("rdboth_hit", s_hit, 32'd5);
    MemWrite = 1; addr = 10'h010; data_in = 32'hFFFF0000;
    #1;
    check("mid_stall0", 32'(s_stall), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    check("mid_rst_stall", 32'(s_stall), 32'd0);
    check("mid_rst_dout", s_dout, 32'd0);
    @(negedge clk);
    MemWrite = 0;
    #1;
    check("mid_rst_hit", s_hit, 32'd0);
    check("mid_rst_miss", s_miss, 32'd0);
    reset = 0;
    @(negedge clk);
    op("mid_rd10", 0, 1, 10'h010, 32'h0, 5, 32'h0);
    op("mid_rd4", 0, 1, 10'h004, 32'h0, 5, 32'h11110004);
    check("mid_miss", s_miss, 32'd2);
    sel = 1;
    do_reset();
    op("b_pre1", 1, 0, 10'h001, 32'h00000001, 2, 32'h0);
    op("b_pre9", 1, 0, 10'h009, 32'h00000009, 2, 32'h0);
    op("b_rd1a", 0, 1, 10'h001, 32'h0, 2, 32'h00000001);
    op("b_rd9a", 0, 1, 10'h009, 32'h0, 2, 32'h00000009);
    op("b_rd1b", 0, 1, 10'h001, 32'h0, 2, 32'h00000001);
    op("b_rd9b", 0, 1, 10'h009, 32'h0, 2, 32'h00000009);
    check("b_miss", s_miss, 32'd4);
    check("b_hit", s_hit, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_sys_param.md
Name: data_mem_sys_param

Overview:
- Parametrised data-memory subsystem for the single-cycle/pipelined CPU.
- Direct-mapped, write-through, no-write-allocate cache in front of a word-addressed backing memory with configurable latency.
- Generalises the fixed 32-line/4-word system: configurable geometry and memory latency, resettable valid bits, and hit/miss performance counters.
- Sits between the CPU memory stage and the backing store; the CPU freezes while stall=1.

Parameters:
- ADDR_W, 10, word-address width.
- INDEX_W, 5, log2 of cache lines.
- OFFSET_W, 2, log2 of words per block.
- DATA_W, 32, word width.
- MEM_LAT, 4, backing-memory access cycles (>=1).
- TAG_W is derived: ADDR_W-INDEX_W-OFFSET_W (must be >=1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- MemRead  in  1  read request; held by CPU while stall=1
- MemWrite  in  1  write request; priority over MemRead; held while stall=1
- addr  in  ADDR_W  word address: offset=[OFFSET_W-1:0], index=next INDEX_W bits, tag=upper TAG_W bits
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  read data, valid when MemRead=1 and stall=0
- stall  out  1  freeze CPU
- hit_count  out  32  read hits since reset
- miss_count  out  32  read misses since reset

Behaviour:
- Storage:
  - Per line: valid bit, TAG_W tag, 2^OFFSET_W data words.
  - Backing memory: 2^ADDR_W words, not cleared by reset.
- Reset (synchronous): all valid=0, FSM=IDLE, counters=0. stall=0 and data_out=0 while reset=1.
- hit = valid[index] && tag_store[index]==tag.
- FSM states: IDLE, WAIT, DONE. A down-counter is loaded with MEM_LAT-1 on entry to WAIT.
- IDLE:
  - Read hit: data_out=cached word combinationally, stall=0, hit_count+1.
  - Read miss: stall=1 combinationally, miss_count+1, go to WAIT.
  - Write (hit or miss): stall=1, go to WAIT.
  - No request: stall=0, data_out=0.
- WAIT:
  - stall=1; counter decrements each cycle.
  - At counter==0 (last WAIT cycle), commit the operation:
    - Read: fill the whole block from memory, set valid, write the tag.
    - Write: memory[addr]=data_in; if hit, also update the cached word.
    - Misses never allocate.
  - Then go to DONE.
- DONE:
  - stall=0, counters unchanged, no memory access.
  - Read: data_out=cached word (now a hit).
  - Write: data_out=0; the request is retired, not re-issued.
  - Next state IDLE.
- Latency: every miss and every write holds stall=1 for exactly MEM_LAT+1 cycles, then one DONE cycle with stall=0.
- MemRead and MemWrite both high: treated as a write. data_out=0. No counter change.
- Address or data changes while stall=1 are illegal. The FSM uses the values present on the commit cycle.
- Counters saturate at 32'hFFFFFFFF.
- Reset mid-operation:
  - Aborts with no commit: no fill, no memory write.
  - The next cycle after reset deasserts starts in IDLE with stall=0 (no request) or re-evaluates the request.
- Index wrap: the highest index and index 0 behave identically. Offsets within a block wrap only inside that block.

Test Plan:
- Cold read, defaults, memory preloaded with mem[0x005]=0xDEADBEEF: MemRead addr=0x005 -> stall=1 for 5 cycles, DONE cycle data_out=0xDEADBEEF with stall=0, miss_count=1. Next read of 0x004..0x007 -> stall=0 same cycle, hit_count increments.
- Conflict: after the 0x005 fill, read 0x085 (same index 1, tag 001) -> miss with 5 stall cycles, line replaced. Re-read 0x005 -> miss again, miss_count=3.
- Write hit: line 0x004 resident; MemWrite addr=0x006 data=0x12345678 -> 5 stall cycles. Subsequent read 0x006 is a hit returning 0x12345678, and backing mem[0x006]=0x12345678.
- Write miss: MemWrite addr=0x3F0 data=0xA5A5A5A5 -> 5 stall cycles, valid[index 28] stays 0. Following read 0x3F0 -> miss, then returns 0xA5A5A5A5.
- Reset mid-op: assert reset in the 2nd WAIT cycle of a write to 0x010 (old value 0x0) -> stall=0 during reset, counters=0, mem[0x010] still 0x0, all lines invalid.
- Parameter sweep with MEM_LAT=1, INDEX_W=3, OFFSET_W=0 -> miss stall exactly 2 cycles. Reading the same index with two different tags alternately yields only misses.
